// File: rtl/locked_register_bank.sv
// locked_register_bank: bank of NUM_REGS lockable config registers with a key-gated debug session.
// Latency: writes, locks, FSM state and flags all update on the next rising Clk edge (1 cycle).
// Backpressure: none; rejected writes are dropped and flagged by the sticky wr_err.
// Ports: Clk/reset (sync, active-high); write/addr/Data_in config write; Lock sticky per-reg lock set;
//        debug_mode/trusted/key_valid/key_in session unlock; Data_out packed regs; lock_status, dbg_open,
//        key_fail (1-cycle pulse), wr_err (sticky).
module locked_register_bank #(
  parameter int                DATA_W      = 16,
  parameter int                NUM_REGS    = 4,
  parameter int                ADDR_W      = 2,
  parameter logic [DATA_W-1:0] KEY0        = 16'hA5C3,
  parameter logic [DATA_W-1:0] KEY1        = 16'h3C5A,
  parameter int                SESSION_LEN = 256
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          Data_in,
  input  logic [NUM_REGS-1:0]        Lock,
  input  logic                       debug_mode,
  input  logic                       trusted,
  input  logic                       key_valid,
  input  logic [DATA_W-1:0]          key_in,
  output logic [NUM_REGS*DATA_W-1:0] Data_out,
  output logic [NUM_REGS-1:0]        lock_status,
  output logic                       dbg_open,
  output logic                       key_fail,
  output logic                       wr_err
);

  localparam int CNT_W = $clog2(SESSION_LEN) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_K1, ST_OPEN} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_key_fail, w_key_fail_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_lock;
  logic                r_wr_err;

  logic w_gate;
  logic w_dbg_open;
  logic w_in_range;
  logic w_wr_ok;
  logic w_wr_rej;
  logic w_err_clr;

  assign w_gate     = debug_mode && trusted;
  assign w_dbg_open = (r_state == ST_OPEN);
  assign w_in_range = (int'(addr) < NUM_REGS);

  // Accept/reject uses the pre-edge lock bits and session state, so a lock
  // arriving with a write to the same register only bites from the next cycle.
  assign w_wr_ok   = write && w_in_range && (!r_lock[addr] || w_dbg_open);
  assign w_wr_rej  = write && w_in_range &&  r_lock[addr] && !w_dbg_open;
  assign w_err_clr = w_wr_ok && (addr == '0) && Data_in[DATA_W-1];

  // Session FSM next-state. In K1 a bad word takes priority over a dropped
  // gate so it is always reported.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_key_fail_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gate && key_valid) begin
          if (key_in == KEY0) w_state_nxt    = ST_K1;
          else                w_key_fail_nxt = 1'b1;
        end
      end
      ST_K1: begin
        if (key_valid && (key_in != KEY1)) begin
          w_state_nxt    = ST_IDLE;
          w_key_fail_nxt = 1'b1;
        end else if (!w_gate) begin
          w_state_nxt = ST_IDLE;
        end else if (key_valid) begin
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = '0;
        end
      end
      ST_OPEN: begin
        // Leaving OPEN on the last count keeps the counter from ever wrapping.
        if (!w_gate || (r_cnt == CNT_W'(SESSION_LEN - 1))) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_key_fail <= 1'b0;
      r_lock     <= '0;
      r_wr_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_key_fail <= w_key_fail_nxt;
      r_lock     <= r_lock | Lock;
      if (w_wr_ok) r_regs[addr] <= Data_in;
      if (w_wr_rej)       r_wr_err <= 1'b1;
      else if (w_err_clr) r_wr_err <= 1'b0;
    end
  end

  always_comb begin
    Data_out = '0;
    for (int i = 0; i < NUM_REGS; i++) Data_out[i*DATA_W +: DATA_W] = r_regs[i];
  end

  assign lock_status = r_lock;
  assign dbg_open    = w_dbg_open;
  assign key_fail    = r_key_fail;
  assign wr_err      = r_wr_err;

endmodule
